// File: rtl/smem_line_packer_if.sv
// Result-entry input and packed-line output bundle
// shared by smem_line_packer and its neighbours.
interface smem_line_packer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WIDTH = 512,
   parameter int SEQ_WIDTH  = 16
);
   localparam int ENTRIES = LINE_WIDTH / DATA_WIDTH;
   localparam int CW      = $clog2(ENTRIES) + 1;

   logic [DATA_WIDTH-1:0] In_data;
   logic                  In_last;
   logic                  In_valid;
   logic                  Stall_out;
   logic [LINE_WIDTH-1:0] Line_out;
   logic [CW-1:0]         Line_count;
   logic [SEQ_WIDTH-1:0]  Line_seq;
   logic                  Line_valid;
   logic                  Line_ready;
   logic                  Overflow_err;

   modport master (
      output In_data, In_last, In_valid, Line_ready,
      input  Stall_out, Line_out, Line_count,
      input  Line_seq, Line_valid, Overflow_err
   );

   modport slave (
      input  In_data, In_last, In_valid, Line_ready,
      output Stall_out, Line_out, Line_count,
      output Line_seq, Line_valid, Overflow_err
   );
endinterface

// File: rtl/smem_line_packer.sv
// Packs FIFO result entries into wide lines with an
// assembly stage and a backpressured hold stage.
module smem_line_packer #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WIDTH = 512,
   parameter int SEQ_WIDTH  = 16
) (
   input logic                Clk,
   input logic                Reset_n,
   smem_line_packer_if.slave  bus
);
   localparam int ENTRIES = LINE_WIDTH / DATA_WIDTH;
   localparam int IW      = $clog2(ENTRIES);
   localparam int CW      = IW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(ENTRIES);
   localparam logic [CW-1:0] LAST_SLOT = CW'(ENTRIES - 1);

   logic [ENTRIES-1:0][DATA_WIDTH-1:0] asm_data_q, asm_data_d;
   logic [CW-1:0]         asm_count_q, asm_count_d;
   logic                  asm_full_q, asm_full_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [LINE_WIDTH-1:0] line_out_q, line_out_d;
   logic [CW-1:0]         line_count_q, line_count_d;
   logic [SEQ_WIDTH-1:0]  line_seq_q, line_seq_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic                  ovf_q, ovf_d;
   logic                  transfer;
   logic                  accept;
   logic [CW-1:0]         base;

   // Next state: assembly fill, hold refill/drain, sequence, overflow
   always_comb begin
      transfer     = asm_full_q & (~hold_valid_q | bus.Line_ready);
      accept       = bus.In_valid & (~asm_full_q | transfer);
      base         = transfer ? '0 : asm_count_q;
      asm_data_d   = transfer ? '0 : asm_data_q;
      asm_count_d  = base;
      asm_full_d   = asm_full_q & ~transfer;
      if (accept) begin
         asm_data_d[base[IW-1:0]] = bus.In_data;
         asm_count_d = base + CW'(1);
         asm_full_d  = (asm_count_d == FULL_CNT) | bus.In_last;
      end
      ovf_d        = ovf_q | (bus.In_valid & ~accept);
      hold_valid_d = hold_valid_q & ~bus.Line_ready;
      line_out_d   = line_out_q;
      line_count_d = line_count_q;
      line_seq_d   = line_seq_q;
      seq_d        = seq_q;
      if (transfer) begin
         hold_valid_d = 1'b1;
         line_out_d   = asm_data_q;
         line_count_d = asm_count_q;
         line_seq_d   = seq_q;
         seq_d        = seq_q + SEQ_WIDTH'(1);
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         asm_data_q   <= '0;
         asm_count_q  <= '0;
         asm_full_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         line_out_q   <= '0;
         line_count_q <= '0;
         line_seq_q   <= '0;
         seq_q        <= '0;
         ovf_q        <= 1'b0;
      end else begin
         asm_data_q   <= asm_data_d;
         asm_count_q  <= asm_count_d;
         asm_full_q   <= asm_full_d;
         hold_valid_q <= hold_valid_d;
         line_out_q   <= line_out_d;
         line_count_q <= line_count_d;
         line_seq_q   <= line_seq_d;
         seq_q        <= seq_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.Stall_out = hold_valid_q & ~bus.Line_ready &
                          (asm_full_q | (bus.In_valid &
                          ((asm_count_q == LAST_SLOT) | bus.In_last)));
   assign bus.Line_out     = line_out_q;
   assign bus.Line_count   = line_count_q;
   assign bus.Line_seq     = line_seq_q;
   assign bus.Line_valid   = hold_valid_q;
   assign bus.Overflow_err = ovf_q;
endmodule

// File: tb/tb_smem_line_packer.sv
// Randomized self-checking bench for smem_line_packer
// against a queue-based line reference model.
module tb_smem_line_packer;
   typedef struct packed {
      logic [511:0] line;
      logic [3:0]   cnt;
      logic [15:0]  seq;
   } line_t;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   smem_line_packer_if #(
      .DATA_WIDTH(64), .LINE_WIDTH(512), .SEQ_WIDTH(16)
   ) bus ();

   smem_line_packer #(
      .DATA_WIDTH(64), .LINE_WIDTH(512), .SEQ_WIDTH(16)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   logic stall_prev;
   logic stall_seen;
   line_t exp_q[$];
   line_t got_q[$];
   logic [511:0] m_line;
   int m_cnt;
   logic [15:0] m_seq;

   // Capture every line handed off at the coming edge
   always @(negedge Clk) begin
      if (Reset_n === 1'b1 && bus.Line_valid === 1'b1 &&
          bus.Line_ready === 1'b1)
         got_q.push_back({bus.Line_out, bus.Line_count, bus.Line_seq});
   end

   task automatic tick();
      @(negedge Clk);
      stall_prev = bus.Stall_out;
      if (stall_prev === 1'b1) stall_seen = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic model_reset();
      m_line = '0;
      m_cnt = 0;
      m_seq = '0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic model_push(input logic [63:0] d, input logic l);
      m_line[m_cnt*64 +: 64] = d;
      m_cnt++;
      if (m_cnt == 8 || l) begin
         exp_q.push_back({m_line, 4'(m_cnt), m_seq});
         m_seq++;
         m_line = '0;
         m_cnt = 0;
      end
   endtask

   task automatic send(input logic [63:0] d, input logic l);
      bus.In_valid = 1'b1;
      bus.In_data = d;
      bus.In_last = l;
      model_push(d, l);
      tick();
      bus.In_valid = 1'b0;
      bus.In_last = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      bus.In_valid = 1'b0;
      bus.In_last = 1'b0;
      bus.In_data = '0;
      bus.Line_ready = 1'b0;
      stall_prev = 1'b0;
      stall_seen = 1'b0;
      model_reset();
      tick();
      tick();
      Reset_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (bus.Line_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_valid got=%b exp=0", bus.Line_valid);
      end
      checks++;
      if (bus.Line_out !== '0) begin
         failures++;
         $display("FAIL rst_line got=%h exp=0", bus.Line_out);
      end
      checks++;
      if (bus.Line_count !== 4'd0 || bus.Line_seq !== 16'd0) begin
         failures++;
         $display("FAIL rst_cnt_seq got=%0d/%0d exp=0/0",
                  bus.Line_count, bus.Line_seq);
      end
      checks++;
      if (bus.Overflow_err !== 1'b0 || bus.Stall_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_ovf_stall got=%b%b exp=00",
                  bus.Overflow_err, bus.Stall_out);
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_back_to_back();
      line_t e, g;
      int n;
      bus.Line_ready = 1'b1;
      stall_seen = 1'b0;
      for (int i = 0; i < 16; i++) send(64'(i), 1'b0);
      n = 0;
      while (got_q.size() < exp_q.size() && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (stall_seen !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stall got=%b exp=0", stall_seen);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL b2b_lines got=%0d exp=%0d",
                  got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL b2b_line got seq=%0d cnt=%0d %h exp seq=%0d cnt=%0d %h",
                     g.seq, g.cnt, g.line, e.seq, e.cnt, e.line);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_partial_flush();
      logic [511:0] pl;
      line_t e, g;
      int n;
      pl = '0;
      pl[63:0] = 64'hA;
      pl[127:64] = 64'hB;
      pl[191:128] = 64'hC;
      bus.Line_ready = 1'b1;
      send(64'hA, 1'b0);
      send(64'hB, 1'b0);
      send(64'hC, 1'b1);
      @(negedge Clk);
      checks++;
      if (bus.Line_valid !== 1'b0) begin
         failures++;
         $display("FAIL part_early got=%b exp=0", bus.Line_valid);
      end
      @(posedge Clk);
      #1;
      @(negedge Clk);
      checks++;
      if (bus.Line_valid !== 1'b1 || bus.Line_count !== 4'd3) begin
         failures++;
         $display("FAIL part_valid got v=%b c=%0d exp v=1 c=3",
                  bus.Line_valid, bus.Line_count);
      end
      checks++;
      if (bus.Line_out !== pl) begin
         failures++;
         $display("FAIL part_line got=%h exp=%h", bus.Line_out, pl);
      end
      @(posedge Clk);
      #1;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL part_lines got=%0d exp=%0d",
                  got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL part_q got seq=%0d cnt=%0d %h exp seq=%0d cnt=%0d %h",
                     g.seq, g.cnt, g.line, e.seq, e.cnt, e.line);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [63:0] vals[20];
      line_t e, g;
      int idx, n;
      for (int i = 0; i < 20; i++) vals[i] = {$urandom, $urandom};
      bus.Line_ready = 1'b0;
      stall_prev = 1'b0;
      stall_seen = 1'b0;
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         bus.In_valid = !stall_prev && idx < 20 &&
                        ($urandom_range(0, 3) != 0);
         bus.In_last = (idx == 19);
         bus.In_data = vals[idx % 20];
         if (bus.In_valid) begin
            model_push(vals[idx], idx == 19);
            idx++;
         end
         tick();
      end
      bus.In_valid = 1'b0;
      checks++;
      if (idx != 16 || stall_seen !== 1'b1) begin
         failures++;
         $display("FAIL bp_stall got acc=%0d st=%b exp acc=16 st=1",
                  idx, stall_seen);
      end
      checks++;
      if ({bus.Line_out, bus.Line_count, bus.Line_seq} !== exp_q[0]) begin
         failures++;
         $display("FAIL bp_hold got seq=%0d %h exp seq=%0d %h",
                  bus.Line_seq, bus.Line_out, exp_q[0].seq, exp_q[0].line);
      end
      bus.Line_ready = 1'b1;
      n = 0;
      while ((idx < 20 || got_q.size() < exp_q.size()) && n < 300) begin
         bus.In_valid = !stall_prev && idx < 20 &&
                        ($urandom_range(0, 1) != 0);
         bus.In_last = (idx == 19);
         bus.In_data = vals[idx % 20];
         if (bus.In_valid) begin
            model_push(vals[idx], idx == 19);
            idx++;
         end
         tick();
         n++;
      end
      bus.In_valid = 1'b0;
      bus.In_last = 1'b0;
      checks++;
      if (got_q.size() != 3 || exp_q.size() != 3) begin
         failures++;
         $display("FAIL bp_lines got=%0d model=%0d exp=3",
                  got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL bp_line got seq=%0d cnt=%0d %h exp seq=%0d cnt=%0d %h",
                     g.seq, g.cnt, g.line, e.seq, e.cnt, e.line);
         end
      end
      checks++;
      if (bus.Overflow_err !== 1'b0) begin
         failures++;
         $display("FAIL bp_ovf got=%b exp=0", bus.Overflow_err);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_overflow();
      line_t e, g;
      int n;
      bus.Line_ready = 1'b0;
      for (int i = 0; i < 16; i++) send({$urandom, $urandom}, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.In_valid = 1'b1;
         bus.In_data = {$urandom, $urandom};
         tick();
      end
      bus.In_valid = 1'b0;
      checks++;
      if (bus.Overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got=%b exp=1", bus.Overflow_err);
      end
      tick();
      tick();
      checks++;
      if ({bus.Line_out, bus.Line_count, bus.Line_seq} !== exp_q[0]) begin
         failures++;
         $display("FAIL ovf_hold got seq=%0d %h exp seq=%0d %h",
                  bus.Line_seq, bus.Line_out, exp_q[0].seq, exp_q[0].line);
      end
      bus.Line_ready = 1'b1;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 50) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL ovf_lines got=%0d exp=%0d",
                  got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL ovf_line got seq=%0d cnt=%0d %h exp seq=%0d cnt=%0d %h",
                     g.seq, g.cnt, g.line, e.seq, e.cnt, e.line);
         end
      end
      checks++;
      if (bus.Overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", bus.Overflow_err);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      line_t e, g;
      int n;
      bus.Line_ready = 1'b0;
      for (int i = 0; i < 12; i++) send({$urandom, $urandom}, 1'b0);
      Reset_n = 1'b0;
      tick();
      @(negedge Clk);
      model_reset();
      checks++;
      if (bus.Line_valid !== 1'b0 || bus.Line_out !== '0) begin
         failures++;
         $display("FAIL mid_line got v=%b %h exp v=0 0",
                  bus.Line_valid, bus.Line_out);
      end
      checks++;
      if (bus.Line_count !== 4'd0 || bus.Line_seq !== 16'd0 ||
          bus.Overflow_err !== 1'b0 || bus.Stall_out !== 1'b0) begin
         failures++;
         $display("FAIL mid_misc got c=%0d s=%0d o=%b st=%b exp 0",
                  bus.Line_count, bus.Line_seq, bus.Overflow_err,
                  bus.Stall_out);
      end
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      bus.Line_ready = 1'b1;
      for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'b0);
      n = 0;
      while (got_q.size() < exp_q.size() && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         failures++;
         $display("FAIL mid_lines got=%0d model=%0d exp=1",
                  got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL mid_line2 got seq=%0d cnt=%0d %h exp seq=%0d cnt=%0d %h",
                     g.seq, g.cnt, g.line, e.seq, e.cnt, e.line);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_seq_wrap();
      line_t e, g;
      logic [15:0] prev;
      logic wrapped;
      int n, bad;
      bus.Line_ready = 1'b1;
      for (int i = 0; i < 65537; i++) send({$urandom, $urandom}, 1'b1);
      n = 0;
      while (got_q.size() < exp_q.size() && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL wrap_lines got=%0d exp=%0d",
                  got_q.size(), exp_q.size());
      end
      wrapped = 1'b0;
      prev = 16'h0;
      bad = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         if (prev == 16'hFFFF && g.seq == 16'h0) wrapped = 1'b1;
         prev = g.seq;
         checks++;
         if (g !== e) begin
            failures++;
            bad++;
            if (bad < 5)
               $display("FAIL wrap_line got seq=%0d cnt=%0d exp seq=%0d cnt=%0d",
                        g.seq, g.cnt, e.seq, e.cnt);
         end
      end
      checks++;
      if (wrapped !== 1'b1) begin
         failures++;
         $display("FAIL wrap_seq got=%b exp=1", wrapped);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_partial_flush();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_seq_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
